// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// The ALU control codes are the same values the ALU decoder emits.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [4:0] ALU_MUL   = 5'b01000;
  localparam logic [4:0] ALU_MULH  = 5'b01001;
  localparam logic [4:0] ALU_MULHU = 5'b01011;
  localparam logic [4:0] ALU_DIV   = 5'b01100;
  localparam logic [4:0] ALU_DIVU  = 5'b01101;
  localparam logic [4:0] ALU_REM   = 5'b01110;
  localparam logic [4:0] ALU_REMU  = 5'b01111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the four divide-family codes (selects the restoring-subtract step).
  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  // True where operands are interpreted as two's complement.
  function automatic logic is_signed_op(input logic [4:0] code);
    return (code == ALU_MUL) || (code == ALU_MULH) ||
           (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath.
// mode_div=0: shift-add multiply step on the {hi,lo} accumulator, opnd is
//             the multiplicand magnitude, lo holds the remaining multiplier bits.
// mode_div=1: restoring-divide step; hi is the partial remainder, lo shifts
//             the dividend out at the top and the quotient bits in at the bottom.
module mdu_step
  import mdu_pkg::*;
(
  input  logic            mode_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          fits;

  // Both step flavours computed combinationally, mode selects which is used.
  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
    shifted = {hi_in, lo_in[XLEN-1]};
    fits    = (shifted >= {1'b0, opnd});
    if (mode_div) begin
      // The remainder after a successful subtract is below the divisor, so
      // 32-bit arithmetic is exact here.
      hi_out = fits ? (shifted[XLEN-1:0] - opnd) : shifted[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], fits};
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake.
// Operates on magnitudes and applies the result sign on the final step.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// CALC  | one multiply or divide step per cycle, cnt counts 0..31
// DONE  | result held, out_valid high until out_ready
module mdu_iter_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        op;
  logic              neg;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   opnd;

  logic              accept;
  logic              last_step;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              sign_in;
  logic              b_zero;
  logic              div_ovf;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN-1:0]   step_hi;
  logic [XLEN-1:0]   step_lo;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  assign accept    = in_valid && in_ready && !flush;
  assign last_step = (cnt == CNT_W'(ITER - 1));

  mdu_step u_step (
    .mode_div (is_div_op(op)),
    .hi_in    (hi),
    .lo_in    (lo),
    .opnd     (opnd),
    .hi_out   (step_hi),
    .lo_out   (step_lo)
  );

  // Operand magnitudes, result sign and the early-completion cases.
  always_comb begin
    a_neg    = is_signed_op(alu_ctrl) && src_a[XLEN-1];
    b_neg    = is_signed_op(alu_ctrl) && src_b[XLEN-1];
    mag_a    = a_neg ? (~src_a + 32'd1) : src_a;
    mag_b    = b_neg ? (~src_b + 32'd1) : src_b;
    b_zero   = (src_b == '0);
    div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    sign_in  = 1'b0;
    fast_hit = 1'b0;
    fast_res = '0;
    case (alu_ctrl)
      ALU_MUL, ALU_MULH: sign_in = a_neg ^ b_neg;
      ALU_MULHU: sign_in = 1'b0;
      ALU_DIV: begin
        sign_in = a_neg ^ b_neg;
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          fast_hit = 1'b1;
          fast_res = 32'h8000_0000;
        end
      end
      ALU_DIVU: begin
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = 32'hFFFF_FFFF;
        end
      end
      ALU_REM: begin
        sign_in = a_neg;
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = src_a;
        end else if (div_ovf) begin
          fast_hit = 1'b1;
          fast_res = '0;
        end
      end
      ALU_REMU: begin
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = src_a;
        end
      end
      default: begin
        // Codes the unit does not implement complete at once with zero.
        fast_hit = 1'b1;
        fast_res = '0;
      end
    endcase
  end

  // Sign correction applied to the output of the final step.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg ? (~prod + 64'd1) : prod;
    quo_fix  = neg ? (~step_lo + 32'd1) : step_lo;
    rem_fix  = neg ? (~step_hi + 32'd1) : step_hi;
    case (op)
      ALU_MUL:             final_res = prod_fix[XLEN-1:0];
      ALU_MULH, ALU_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:   final_res = quo_fix;
      ALU_REM, ALU_REMU:   final_res = rem_fix;
      default:             final_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_nx = fast_hit ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
    end
  end

  // Operand capture on accept, iteration in CALC, result load on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op     <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      result <= '0;
    end else if (accept) begin
      op   <= alu_ctrl;
      neg  <= sign_in;
      cnt  <= '0;
      hi   <= '0;
      opnd <= is_div_op(alu_ctrl) ? mag_b : mag_a;
      lo   <= is_div_op(alu_ctrl) ? mag_a : mag_b;
      if (fast_hit) begin
        result <= fast_res;
      end
    end else if ((state == CALC) && !flush) begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt + 1'b1;
      if (last_step) begin
        result <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Scoreboard bench for mdu_iter_unit: the driver pushes expected results
// and latencies, the monitor pops and compares on each out handshake.
module tb_mdu_iter_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_ctrl = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          lat;  // edges from the accept edge to first visible out_valid
    int          c0;   // edge count of the accept edge
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          bp_hold = 0;
  int          last_hs = 0;
  logic        seen = 1'b0;
  logic [31:0] held = '0;

  mdu_iter_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics via 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_MUL:   begin p = 64'(sa * sb); return p[31:0]; end
      ALU_MULH:  begin p = 64'(sa * sb); return p[63:32]; end
      ALU_MULHU: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      ALU_DIV:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      ALU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:   begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      ALU_REMU:  return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHU: return 32;
      ALU_DIV, ALU_REM:             return ((b == 0) || ovf) ? 0 : 32;
      ALU_DIVU, ALU_REMU:           return (b == 0) ? 0 : 32;
      default:                      return 0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Offer one operation, wait (bounded) for acceptance, push its expectation.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, output int c0);
    int   budget;
    exp_t e;
    budget = 0;
    c0     = -1;
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", budget);
      in_valid = 1'b0;
    end else begin
      e.res = expv;
      e.lat = exp_lat(op, a, b);
      e.c0  = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      c0       = cyc;
      in_valid = 1'b0;
      alu_ctrl = 5'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb_q.size() != 0 || busy) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, busy=%b, required 0/0", sb_q.size(), busy);
      sb_q.delete();
    end
  endtask

  // Monitor: drives out_ready, checks latency, hold stability and results.
  always @(negedge clk) begin : mon
    logic rdy;
    if (!rst_n) begin
      seen      = 1'b0;
      out_ready = 1'b0;
    end else begin
      rdy = ($urandom_range(0, 3) != 0);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=1 result %h, required no output", result);
          rdy = 1'b1;
        end else begin
          if (!seen) begin
            check_int("latency", cyc - sb_q[0].c0, sb_q[0].lat);
            seen = 1'b1;
            held = result;
          end else begin
            check32("hold_stable", result, held);
          end
          if (bp_hold > 0) begin
            rdy = 1'b0;
            bp_hold--;
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_bit("bp_busy", busy, 1'b1);
          end
          if (rdy) begin
            check32("result", result, sb_q[0].res);
            void'(sb_q.pop_front());
            seen    = 1'b0;
            last_hs = cyc + 1;
          end
        end
      end
      out_ready = rdy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          c1;
    logic [4:0]  codes [7];
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    codes = '{ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    #12;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check32("rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with expected values written out.
    issue(ALU_MUL,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, c0); drain();
    issue(ALU_MULH,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, c0); drain();
    issue(ALU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, c0); drain();
    issue(ALU_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, c0); drain();
    issue(ALU_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, c0); drain();
    issue(ALU_DIVU,  32'd100,        32'd7,         32'd14,        c0); drain();
    issue(ALU_REMU,  32'd100,        32'd7,         32'd2,         c0); drain();
    issue(ALU_DIV,   32'd5,          32'd0,         32'hFFFF_FFFF, c0); drain();
    issue(ALU_REMU,  32'd5,          32'd0,         32'd5,         c0); drain();
    issue(ALU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, c0); drain();
    issue(ALU_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         c0); drain();
    issue(5'b00011,  32'd9,          32'd9,         32'h0,         c0); drain();

    // Random operations, back to back, with random backpressure.
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 6)];
      a  = rnd_opnd();
      b  = rnd_opnd();
      issue(op, a, b, ref_model(op, a, b), c0);
    end
    drain();

    // Backpressure for 5 cycles, then the next op one cycle after DONE->IDLE.
    bp_hold = 5;
    issue(ALU_DIVU, 32'd1000, 32'd9, 32'd111, c0);
    issue(ALU_MUL, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, c1);
    check_int("b2b_accept_edge", c1, last_hs + 1);
    drain();

    // Flush at cnt==10: no result may appear.
    issue(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, c0);
    while (cyc < c0 + 10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(sb_q.pop_back());
    check_bit("flush_in_ready", in_ready, 1'b1);
    check_bit("flush_busy", busy, 1'b0);
    check_bit("flush_out_valid", out_valid, 1'b0);
    repeat (40) @(negedge clk);

    // in_valid together with flush in IDLE is not accepted.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    alu_ctrl = ALU_MUL;
    src_a    = 32'd3;
    src_b    = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_bit("idle_flush_in_ready", in_ready, 1'b1);
    check_bit("idle_flush_busy", busy, 1'b0);
    repeat (40) @(negedge clk);

    // Reset mid-CALC.
    issue(ALU_MUL, 32'h0001_2345, 32'h0000_6789, 32'h0, c0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    check32("midrst_result", result, 32'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(ALU_MUL, 32'd3, 32'd4, 32'd12, c0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter_unit.md
# mdu_iter_unit

Iterative multiply/divide unit on the execute stage, directly downstream of the ALU decoder. It consumes the 5-bit ALU control code and two 32-bit operands for the RV32M operations the decoder emits, and computes the result over 32 clock cycles. Results return through a valid/ready handshake so the pipeline can stall on it. Divide-by-zero and signed overflow complete early.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers an operation.
- in_ready  out  1  unit can accept; high only in IDLE.
- alu_ctrl  in  5  ALU control code: 01000 mul, 01001 mulh, 01011 mulhu, 01100 div, 01101 divu, 01110 rem, 01111 remu.
- src_a  in  32  dividend / multiplicand.
- src_b  in  32  divisor / multiplier.
- flush  in  1  kill the in-flight operation.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream takes the result.
- result  out  32  operation result.
- busy  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- Accept occurs when in_valid && in_ready && !flush. On accept, the unit latches alu_ctrl and both operand magnitudes, plus the result-sign bit.
  - mul, mulh: magnitudes are signed. Product sign is a[31]^b[31].
  - div: quotient sign is a^b; remainder sign follows the dividend.
  - rem: remainder sign follows the dividend.
  - mulhu, divu, remu: operands are treated as unsigned.
- Fast path (IDLE→DONE on the accept edge, result loaded directly):
  - div/divu with src_b=0: result 0xFFFFFFFF.
  - rem/remu with src_b=0: result src_a.
  - div with src_a=0x80000000 and src_b=0xFFFFFFFF: result 0x80000000.
  - rem with src_a=0x80000000 and src_b=0xFFFFFFFF: result 0.
  - Any alu_ctrl outside the seven codes: result 0.
- Otherwise, on accept: IDLE→CALC, with cnt=0.
- CALC performs one step per cycle and increments cnt. After the step with cnt==31, it goes CALC→DONE and applies the sign fix on that edge.
  - Multiply: 64-bit shift-add accumulator. mul returns the low 32 bits of the signed-corrected product. mulh and mulhu return the high 32 bits.
  - Divide: restoring division with a 33-bit partial remainder and a 32-bit quotient shift register. div/divu return the quotient; rem/remu return the remainder. Negation is two's complement, modulo 2^32.
- DONE: out_valid=1 and result is held stable. On out_valid && out_ready the unit goes DONE→IDLE.
- flush:
  - Any state→IDLE at the next edge; out_valid drops and no result is delivered.
  - flush has priority over accept and over the out handshake.
  - In IDLE, in_valid with flush is not accepted.

## Timing
- Reset values (asynchronous, rst_n=0): state=IDLE, cnt=0, result=0, out_valid=0, busy=0, in_ready=1.
- Iterative latency: out_valid is high in the cycle after edge E0+32, where E0 is the accept edge.
- Fast-path latency: out_valid is high in the cycle after E0.
- Back-to-back accept is not possible in the same cycle as the out handshake. The next accept is earliest one cycle after DONE→IDLE.
- out_valid stays high and result is unchanged for as long as out_ready=0.
- src_a, src_b and alu_ctrl are ignored after the accept edge; they may change freely.
- Reset asserted mid-CALC or in DONE returns the unit to the reset values immediately, and the operation is lost.

## Structure
- Shared package mdu_pkg holds:
  - the seven ALU control code constants (shared with the decoder);
  - the state enum {IDLE, CALC, DONE};
  - the constant ITER=32.
- One sub-module, mdu_step, is natural. It is the combinational single-iteration datapath: one shift-add step or one restoring-subtract step, selected by a mode bit.
- The top module owns the FSM, counter, operand/sign registers and the handshake.

## Test plan
- Multiply, signed and unsigned:
  - mul 7 × 0xFFFFFFFD → 0xFFFFFFEB; out_valid 32 cycles after accept.
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Divide and remainder:
  - div 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - rem 0xFFFFFFF9 % 2 → 0xFFFFFFFF.
  - divu 100 / 7 → 14.
  - remu 100 % 7 → 2.
- Early completion:
  - div 5/0 → 0xFFFFFFFF.
  - remu 5/0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - rem 0x80000000 / 0xFFFFFFFF → 0.
  - All of these raise out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, busy=1. Then out_ready=1 → IDLE, and the next op is accepted one cycle later.
- Flush: assert flush at CALC cnt=10 → IDLE next edge, out_valid never rises. Assert flush with in_valid in IDLE → no accept.
- Reset: drop rst_n mid-CALC → out_valid=0, in_ready=1, result=0 asynchronously. After release, a new mul 3×4 → 12.
